// File: rtl/shiftee_mux.sv
// Selects the barrel-shifter input from the sign-extended 8-bit immediate, Rm, or the 32-bit
// immediate. The selection is also registered, and a sticky flag records any reserved select seen.
module shiftee_mux (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sel,
  input  logic [7:0]  immed_8,
  input  logic [31:0] immed_32,
  input  logic [31:0] rm,
  output logic [31:0] shiftee,
  output logic [31:0] shiftee_q,
  output logic        sel_err
);

  typedef enum logic [1:0] {
    SelImm8  = 2'b00,
    SelRm    = 2'b01,
    SelImm32 = 2'b10,
    SelRsvd  = 2'b11
  } sel_e;

  logic sel_err_d;

  // Every code is decoded explicitly, so no state can be held between input changes.
  always_comb begin
    shiftee = 32'h0000_0000;
    case (sel)
      SelImm8:  shiftee = {{24{immed_8[7]}}, immed_8};
      SelRm:    shiftee = rm;
      SelImm32: shiftee = immed_32;
      SelRsvd:  shiftee = 32'h0000_0000;
      default:  shiftee = 32'h0000_0000;
    endcase
  end

  always_comb begin
    sel_err_d = sel_err | (sel == SelRsvd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shiftee_q <= 32'h0000_0000;
      sel_err   <= 1'b0;
    end else begin
      shiftee_q <= shiftee;
      sel_err   <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_shiftee_mux.sv
// Directed bench for shiftee_mux: operand selection, sign extension, the register stage, the
// sticky reserved-select flag and asynchronous reset.
module tb_shiftee_mux;

  logic        clk;
  logic        reset;
  logic [1:0]  sel;
  logic [7:0]  immed_8;
  logic [31:0] immed_32;
  logic [31:0] rm;
  logic [31:0] shiftee;
  logic [31:0] shiftee_q;
  logic        sel_err;

  int errors = 0;
  int checks = 0;

  shiftee_mux dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .immed_8  (immed_8),
    .immed_32 (immed_32),
    .rm       (rm),
    .shiftee  (shiftee),
    .shiftee_q(shiftee_q),
    .sel_err  (sel_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] model;
    logic [31:0] exp8;

    reset    = 1'b1;
    sel      = 2'b00;
    immed_8  = 8'h00;
    immed_32 = 32'h0;
    rm       = 32'h0;
    #1;
    check("reset_shiftee_q", shiftee_q, 32'h0);
    check("reset_sel_err", {31'h0, sel_err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Sign-extension sweep of the 8-bit immediate.
    sel = 2'b00;
    for (int i = 0; i < 256; i++) begin
      immed_8 = i[7:0];
      #1;
      exp8 = (i >= 128) ? (32'hFFFF_FF00 | i[31:0]) : i[31:0];
      check("imm8_sweep", shiftee, exp8);
    end
    immed_8 = 8'h7F; #1; check("imm8_7f", shiftee, 32'h0000_007F);
    immed_8 = 8'h80; #1; check("imm8_80", shiftee, 32'hFFFF_FF80);
    immed_8 = 8'hFF; #1; check("imm8_ff", shiftee, 32'hFFFF_FFFF);

    // Rm grown one bit at a time.
    sel   = 2'b01;
    model = 32'h0;
    rm    = model;
    #1;
    check("rm_zero", shiftee, 32'h0);
    for (int b = 0; b < 32; b++) begin
      model = (model << 1) | 32'h1;
      rm[b] = 1'b1;
      #1;
      check("rm_grow", shiftee, model);
    end
    check("rm_full", shiftee, 32'hFFFF_FFFF);

    // 32-bit immediate must ignore the unselected operands.
    sel      = 2'b10;
    immed_32 = 32'hDEAD_BEEF;
    for (int k = 0; k < 6; k++) begin
      rm      = 32'h0F0F_0000 ^ (32'h1111_1111 * k);
      immed_8 = 8'h80 + 8'(k * 23);
      #1;
      check("imm32_hold", shiftee, 32'hDEAD_BEEF);
    end
    @(posedge clk); #1;
    check("imm32_reg", shiftee_q, 32'hDEAD_BEEF);
    check("no_err_yet", {31'h0, sel_err}, 32'h0);

    // Reserved select sets the sticky flag on the next edge.
    @(negedge clk);
    sel = 2'b11;
    #1;
    check("rsvd_zero", shiftee, 32'h0);
    check("err_before_edge", {31'h0, sel_err}, 32'h0);
    @(posedge clk); #1;
    check("err_set", {31'h0, sel_err}, 32'h1);
    check("rsvd_reg", shiftee_q, 32'h0);
    @(negedge clk);
    sel     = 2'b00;
    immed_8 = 8'h05;
    @(posedge clk); #1;
    check("err_sticky", {31'h0, sel_err}, 32'h1);
    check("imm8_reg", shiftee_q, 32'h0000_0005);

    // Register latency, then asynchronous reset between edges.
    @(negedge clk);
    sel = 2'b01;
    rm  = 32'h1234_5678;
    #1;
    check("latency_old", shiftee_q, 32'h0000_0005);
    @(posedge clk); #1;
    check("rm_reg", shiftee_q, 32'h1234_5678);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_q", shiftee_q, 32'h0);
    check("async_rst_err", {31'h0, sel_err}, 32'h0);
    check("rst_comb_pass", shiftee, 32'h1234_5678);
    @(posedge clk); #1;
    check("rst_held_q", shiftee_q, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("deassert_no_load", shiftee_q, 32'h0);
    @(posedge clk); #1;
    check("resume_load", shiftee_q, 32'h1234_5678);
    check("resume_err", {31'h0, sel_err}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/shiftee_mux.md
SHIFTEE_MUX -- requirements
Module: shiftee_mux

Interface
REQ-001 Parameter: none; all data widths fixed (immediate 8 bits, operands 32 bits).
REQ-002 clk  input  1  single clock; rising-edge active for all registered state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sel  input  2  shiftee source select: 00 immed_8, 01 rm, 10 immed_32, 11 reserved.
REQ-005 immed_8  input  8  8-bit immediate operand, two's complement.
REQ-006 immed_32  input  32  full 32-bit immediate operand.
REQ-007 rm  input  32  register-file operand Rm.
REQ-008 shiftee  output  32  combinational selected operand for the shifter.
REQ-009 shiftee_q  output  32  shiftee registered on clk.
REQ-010 sel_err  output  1  sticky flag: reserved select value sampled.
REQ-011 Port order: clk, reset, sel, immed_8, immed_32, rm, shiftee, shiftee_q, sel_err.

Function
REQ-012 shiftee SHALL be purely combinational from sel, immed_8, immed_32 and rm, with no dependence on clk or reset.
REQ-013 sel=00: shiftee SHALL equal immed_8 sign-extended to 32 bits, i.e. {24{immed_8[7]}, immed_8}.
REQ-014 sel=01: shiftee SHALL equal rm bit-for-bit.
REQ-015 sel=10: shiftee SHALL equal immed_32 bit-for-bit.
REQ-016 sel=11: shiftee SHALL be 32'h0000_0000.
REQ-017 shiftee SHALL settle in the same simulation time step as any input change, with no latch inference and no glitch-holding state.
REQ-018 Unselected inputs SHALL have no effect on shiftee.
REQ-019 On each rising clk edge with reset low, shiftee_q SHALL load the current shiftee value; latency is 1 cycle.
REQ-020 On a rising clk edge with sel=11 and reset low, sel_err SHALL be set to 1.
REQ-021 Once set, sel_err SHALL remain 1 until reset.
REQ-022 X/Z on sel SHALL NOT be required to produce defined output; all 4 defined codes SHALL be fully decoded (no default-to-latch).

Reset
REQ-023 While reset is high, shiftee_q SHALL be 32'h0000_0000 and sel_err SHALL be 0, independent of clk.
REQ-024 Reset assertion SHALL take effect immediately (asynchronously); deassertion SHALL be honoured at the next rising clk edge.
REQ-025 Reset SHALL NOT affect the combinational shiftee output.
REQ-026 Reset asserted mid-operation SHALL clear shiftee_q and sel_err within the same time step; normal loading resumes on the first rising edge after deassertion.

Verification
REQ-027 Sweep immed_8 0..255 with sel=00 -> shiftee = sign-extension every step; check 0x7F -> 0x0000007F, 0x80 -> 0xFFFFFF80, 0xFF -> 0xFFFFFFFF.
REQ-028 Set sel=01 and grow rm one bit at a time from 0 to 0xFFFFFFFF -> shiftee equals rm after every change.
REQ-029 Set sel=10 with immed_32=0xDEADBEEF while toggling rm and immed_8 -> shiftee stays 0xDEADBEEF.
REQ-030 Set sel=11 and clock once -> shiftee=0, sel_err=1; then set sel=00 -> sel_err stays 1.
REQ-031 Set sel=01 with rm=0x12345678 and clock -> shiftee_q=0x12345678 one edge later; assert reset between edges -> shiftee_q=0 and sel_err=0 immediately, while shiftee stays 0x12345678.
